// File: rtl/mips_pkg.sv
// Shared fetch-stage types and helpers for the MIPS core front end.
// The FETCH_BOUNDS_CHECK_EN build option is consumed by inst_fetch_ctrl.
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } fetch_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

    // True when a word fetched at pc would run past the end of a memory of limit bytes.
    function automatic logic beyond_imem(input logic [WORD_W-1:0] pc, input int unsigned limit);
        logic [WORD_W:0] end_addr;
        end_addr = {1'b0, pc} + (WORD_W+1)'(INST_BYTES);
        return end_addr > (WORD_W+1)'(limit);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue with a flush input; the head entry is presented without a read bubble.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_wr_s;
    logic             do_rd_s;

    // A write into a full queue is legal only when the head leaves in the same cycle.
    always_comb begin
        do_rd_s = 1'b0;
        do_wr_s = 1'b0;
        if (flush) begin
            do_rd_s = 1'b0;
            do_wr_s = 1'b0;
        end else begin
            do_rd_s = rd_en && (count_r != CW'(0));
            do_wr_s = wr_en && ((count_r != CW'(DEPTH)) || do_rd_s);
        end
    end

    // Storage, pointers and occupancy; reset also zeroes storage so the head reads 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else if (flush) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_wr_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == CW'(0));

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, the fetch FSM and the fetch queue to decode.
// Build option FETCH_BOUNDS_CHECK_EN enables memory-bounds / alignment fault detection.
module inst_fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 160,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam int EW = 2 * WORD_W;
    localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(INST_BYTES);

    // Reject configurations the pointer arithmetic and PC sequencing cannot honour.
    if ((FIFO_DEPTH < 32'd2) || ((FIFO_DEPTH & (FIFO_DEPTH - 32'd1)) != 32'd0) ||
        (RESET_PC[1:0] != 2'b00) || (IMEM_BYTES < 32'(INST_BYTES))) begin : g_bad_config
        $error("inst_fetch_ctrl: illegal parameter set");
    end

    fetch_state_e      state_r;
    logic [WORD_W-1:0] pc_r;
    logic              fault_r;
    logic              full_s;
    logic              empty_s;
    logic [EW-1:0]     head_s;
    logic              deq_s;
    logic              want_s;
    logic              enq_s;
`ifdef FETCH_BOUNDS_CHECK_EN
    logic              oob_s;
`endif

    // A redirect suppresses both queue ports; halt_req blocks the fetch of its own cycle.
    always_comb begin
        deq_s  = 1'b0;
        want_s = 1'b0;
        enq_s  = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
        oob_s  = 1'b0;
`endif
        if (redirect_valid) begin
            deq_s  = 1'b0;
            want_s = 1'b0;
            enq_s  = 1'b0;
        end else begin
            deq_s  = !empty_s && inst_ready;
            want_s = (state_r == FETCH) && !halt_req && (!full_s || deq_s);
`ifdef FETCH_BOUNDS_CHECK_EN
            oob_s  = beyond_imem(pc_r, IMEM_BYTES);
            enq_s  = want_s && !oob_s;
`else
            enq_s  = want_s;
`endif
        end
    end

    // PC, fetch state and sticky fault flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC;
            state_r <= FETCH;
            fault_r <= 1'b0;
        end else if (redirect_valid) begin
`ifdef FETCH_BOUNDS_CHECK_EN
            pc_r <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                state_r <= FAULT;
                fault_r <= 1'b1;
            end else begin
                state_r <= FETCH;
                fault_r <= 1'b0;
            end
`else
            pc_r    <= align_word(redirect_pc);
            state_r <= FETCH;
            fault_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                FETCH: begin
                    if (halt_req) begin
                        state_r <= HALTED;
`ifdef FETCH_BOUNDS_CHECK_EN
                    end else if (want_s && oob_s) begin
                        state_r <= FAULT;
                        fault_r <= 1'b1;
`endif
                    end else if (enq_s) begin
                        pc_r <= pc_r + PC_STEP;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                HALTED:  state_r <= HALTED;
                FAULT:   state_r <= FAULT;
                default: state_r <= FETCH;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect_valid),
        .wr_en   (enq_s),
        .wr_data ({imem_data, pc_r}),
        .rd_en   (deq_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    assign imem_addr   = pc_r;
    assign inst_valid  = !empty_s;
    assign inst_data   = head_s[EW-1:WORD_W];
    assign inst_pc     = head_s[WORD_W-1:0];
    assign fetch_fault = fault_r;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: a behavioural model pushes expected {data, pc} entries.
module tb_inst_fetch_ctrl;

    localparam int unsigned IMEM_BYTES = 160;
    localparam int          DEPTH      = 2;
    localparam int          S_FETCH    = 0;
    localparam int          S_HALTED   = 1;
    localparam int          S_FAULT    = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    logic [7:0]  mem_bytes [IMEM_BYTES];
    logic [63:0] exp_q [$];
    logic [31:0] m_pc;
    int          m_state;
    logic        m_fault;
    int          vectors     = 0;
    int          miscompares = 0;

    inst_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (IMEM_BYTES),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian word read; addresses past the array return a tagged pattern.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        int i;
        if (({1'b0, a} + 33'd3) < 33'(IMEM_BYTES)) begin
            i = int'(a);
            return {mem_bytes[i], mem_bytes[i+1], mem_bytes[i+2], mem_bytes[i+3]};
        end
        return {16'hF00D, a[15:0]};
    endfunction

    assign imem_data = word_at(imem_addr);

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
        inst_ready     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_q.delete();
        m_pc    = 32'h0;
        m_state = S_FETCH;
        m_fault = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the reference model, land on the next falling edge.
    task automatic drive_cycle(input logic rv, input logic [31:0] rpc, input logic hr, input logic rdy);
        logic deq;
        logic slot;
        logic oob;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
        inst_ready     = rdy;
        if (rv) begin
            exp_q.delete();
`ifdef FETCH_BOUNDS_CHECK_EN
            m_pc = rpc;
            if (rpc[1:0] != 2'b00) begin
                m_state = S_FAULT;
                m_fault = 1'b1;
            end else begin
                m_state = S_FETCH;
                m_fault = 1'b0;
            end
`else
            m_pc    = {rpc[31:2], 2'b00};
            m_state = S_FETCH;
`endif
        end else begin
            deq  = (exp_q.size() != 0) && rdy;
            slot = (exp_q.size() < DEPTH) || deq;
            if (deq) void'(exp_q.pop_front());
            if (m_state == S_FETCH) begin
                if (hr) begin
                    m_state = S_HALTED;
                end else if (slot) begin
                    oob = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
                    oob = ({1'b0, m_pc} + 33'd4) > 33'(IMEM_BYTES);
`endif
                    if (oob) begin
                        m_state = S_FAULT;
                        m_fault = 1'b1;
                    end else begin
                        exp_q.push_back({word_at(m_pc), m_pc});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({inst_valid, fetch_fault} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_flags: valid/fault got %b want 00", {inst_valid, fetch_fault});
        end
        vectors++;
        if ({inst_data, inst_pc, imem_addr} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_values: data %h pc %h addr %h, want all 0", inst_data, inst_pc, imem_addr);
        end
        repeat (3) drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        do_reset();
        vectors++;
        if ({inst_valid, inst_data, inst_pc, imem_addr} !== 97'h0) begin
            miscompares++;
            $display("FAIL reset_midop: valid %b data %h pc %h addr %h, want all 0",
                     inst_valid, inst_data, inst_pc, imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [63:0] head;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
            vectors++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * c)) begin
                miscompares++;
                $display("FAIL stream_pc: cycle %0d valid %b pc %h, want 1 %h", c, inst_valid, inst_pc, 32'(4 * c));
            end
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                vectors++;
                if (inst_data !== head[63:32]) begin
                    miscompares++;
                    $display("FAIL stream_data: cycle %0d got %h want %h", c, inst_data, head[63:32]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] head;
        do_reset();
        repeat (5) drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (imem_addr !== 32'h8 || inst_pc !== 32'h0 || inst_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_hold: addr %h pc %h valid %b, want 8 0 1", imem_addr, inst_pc, inst_valid);
        end
        for (int c = 0; c < 8; c++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
            head = exp_q[0];
            vectors++;
            if (inst_valid !== 1'b1 || {inst_data, inst_pc} !== head) begin
                miscompares++;
                $display("FAIL stall_resume: cycle %0d got %h/%h want %h/%h", c, inst_data, inst_pc,
                         head[63:32], head[31:0]);
            end
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        repeat (3) drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h40, 1'b0, 1'b0);
        vectors++;
        if (inst_valid !== 1'b0 || imem_addr !== 32'h40) begin
            miscompares++;
            $display("FAIL redirect_flush: valid %b addr %h, want 0 40", inst_valid, imem_addr);
        end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_data !== word_at(32'h40)) begin
            miscompares++;
            $display("FAIL redirect_target: valid %b pc %h data %h, want 1 40 %h",
                     inst_valid, inst_pc, inst_data, word_at(32'h40));
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 10 && m_pc != 32'h10; i++) drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
            vectors++;
            if (imem_addr !== 32'h10 || inst_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_freeze: cycle %0d addr %h valid %b, want 10 0", c, imem_addr, inst_valid);
            end
        end
        drive_cycle(1'b1, 32'h20, 1'b1, 1'b1);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || imem_addr !== 32'h24) begin
            miscompares++;
            $display("FAIL halt_resume: valid %b pc %h addr %h, want 1 20 24", inst_valid, inst_pc, imem_addr);
        end
    endtask

`ifdef FETCH_BOUNDS_CHECK_EN
    task automatic test_bounds();
        do_reset();
        drive_cycle(1'b1, 32'h9C, 1'b0, 1'b1);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (fetch_fault !== 1'b1 || imem_addr !== 32'hA0 || inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bounds_fault: fault %b addr %h valid %b, want 1 a0 0", fetch_fault, imem_addr, inst_valid);
        end
        drive_cycle(1'b1, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (fetch_fault !== 1'b0 || imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL bounds_clear: fault %b addr %h, want 0 0", fetch_fault, imem_addr);
        end
        drive_cycle(1'b1, 32'h42, 1'b0, 1'b1);
        vectors++;
        if (fetch_fault !== 1'b1 || imem_addr !== 32'h42) begin
            miscompares++;
            $display("FAIL misalign_fault: fault %b addr %h, want 1 42", fetch_fault, imem_addr);
        end
    endtask
`else
    task automatic test_misaligned_redirect();
        do_reset();
        drive_cycle(1'b1, 32'h42, 1'b0, 1'b1);
        vectors++;
        if (imem_addr !== 32'h40 || fetch_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_clear: addr %h fault %b, want 40 0", imem_addr, fetch_fault);
        end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
            miscompares++;
            $display("FAIL misalign_fetch: valid %b pc %h, want 1 40", inst_valid, inst_pc);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [63:0] head;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            drive_cycle($urandom_range(0, 15) == 0, 32'($urandom_range(0, 159)),
                        $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
            vectors++;
            if (inst_valid !== (exp_q.size() != 0) || imem_addr !== m_pc || fetch_fault !== m_fault) begin
                miscompares++;
                $display("FAIL b2b_ctrl: cycle %0d valid %b addr %h fault %b, want %b %h %b", c,
                         inst_valid, imem_addr, fetch_fault, exp_q.size() != 0, m_pc, m_fault);
            end
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                vectors++;
                if ({inst_data, inst_pc} !== head) begin
                    miscompares++;
                    $display("FAIL b2b_head: cycle %0d got %h/%h want %h/%h", c, inst_data, inst_pc,
                             head[63:32], head[31:0]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(IMEM_BYTES); i++) mem_bytes[i] = 8'((i * 37 + 11) & 255);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_halt();
`ifdef FETCH_BOUNDS_CHECK_EN
        test_bounds();
`else
        test_misaligned_redirect();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
